stream_mem: RTL

Parametrised single-port synchronous RW memory with a second, streaming read-out path. It serves as the next-generation store for ORA fault-free responses and deterministic test patterns in the LBIST datapath. A host port does word-wise reads and writes. A burst engine streams a contiguous, wrap-around address range to a valid/ready consumer (TPG mux or ORA comparator) at one word per cycle, with backpressure.

---
 rtl/stream_mem_pkg.sv | 18 +
 rtl/stream_mem_if.sv | 33 +++
 rtl/stream_mem_burst_ctrl.sv | 121 ++++++++++++
 rtl/stream_mem.sv | 106 ++++++++++
 4 files changed

// File: rtl/stream_mem_pkg.sv
// Shared types and helpers for stream_mem: burst FSM states, host RW encoding, parity.
package stream_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } burst_state_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // Even-parity bit: the XOR of all data bits, so the stored word XORs to zero.
   function automatic logic even_parity(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/stream_mem_if.sv
// Host and streaming bus of stream_mem; master drives requests, slave is the memory.
interface stream_mem_if #(
   parameter int word_size    = 8,
   parameter int address_bits = 8
);
   logic                    enable;
   logic                    RW;
   logic [address_bits-1:0] add;
   logic [word_size-1:0]    data_w;
   logic [word_size-1:0]    data_r;
   logic                    rd_valid;
   logic                    host_err;
   logic                    burst_start;
   logic [address_bits-1:0] burst_base;
   logic [address_bits:0]   burst_len;
   logic [word_size-1:0]    s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic                    s_last;
   logic                    busy;
   logic                    done;
   logic                    par_err;

   modport master (
      output enable, RW, add, data_w, burst_start, burst_base, burst_len, s_ready,
      input  data_r, rd_valid, host_err, s_data, s_valid, s_last, busy, done, par_err
   );

   modport slave (
      input  enable, RW, add, data_w, burst_start, burst_base, burst_len, s_ready,
      output data_r, rd_valid, host_err, s_data, s_valid, s_last, busy, done, par_err
   );
endinterface

// File: rtl/stream_mem_burst_ctrl.sv
// Burst engine: walks a wrap-around address range and presents one word per handshake.
//
// state  | meaning
// IDLE   | waiting for burst_start, host port owns the array
// STREAM | s_valid asserted, advancing ptr on every handshake
// DONE   | one-cycle done pulse, then back to IDLE
module stream_mem_burst_ctrl
   import stream_mem_pkg::*;
#(
   parameter int word_size    = 8,
   parameter int address_bits = 8,
   parameter int mem_size     = 2**address_bits
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    burst_start,
   input  logic [address_bits-1:0] burst_base,
   input  logic [address_bits:0]   burst_len,
   input  logic                    s_ready,
   input  logic [word_size-1:0]    rd_word,
   output logic [address_bits-1:0] rd_addr,
   output logic                    s_load,
   output logic                    idle,
   output logic [word_size-1:0]    s_data,
   output logic                    s_valid,
   output logic                    s_last,
   output logic                    busy,
   output logic                    done
);

   localparam logic [address_bits-1:0] last_addr = address_bits'(mem_size - 1);

   burst_state_t            state_q, state_d;
   logic [address_bits-1:0] ptr_q, ptr_d, next_ptr;
   logic [address_bits:0]   rem_q, rem_d;
   logic [word_size-1:0]    s_data_q, s_data_d;
   logic                    s_valid_q, s_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   assign next_ptr = (ptr_q == last_addr) ? '0 : ptr_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      s_data_d  = s_data_q;
      s_valid_d = s_valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      s_load    = 1'b0;
      rd_addr   = burst_base;
      case (state_q)
         IDLE: begin
            if (burst_start) begin
               if (burst_len != '0) begin
                  s_load    = 1'b1;
                  s_data_d  = rd_word;
                  s_valid_d = 1'b1;
                  ptr_d     = burst_base;
                  rem_d     = burst_len - 1'b1;
                  busy_d    = 1'b1;
                  state_d   = STREAM;
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         STREAM: begin
            rd_addr = next_ptr;
            if (s_valid_q && s_ready) begin
               if (rem_q != '0) begin
                  s_load   = 1'b1;
                  s_data_d = rd_word;
                  ptr_d    = next_ptr;
                  rem_d    = rem_q - 1'b1;
               end else begin
                  s_valid_d = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            rd_addr = ptr_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         s_data_q  <= '0;
         s_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         s_data_q  <= s_data_d;
         s_valid_q <= s_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign idle    = (state_q == IDLE);
   assign s_data  = s_data_q;
   assign s_valid = s_valid_q;
   assign s_last  = s_valid_q && (rem_q == '0);
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: rtl/stream_mem.sv
// Single-port RW store with a host port and a streaming burst read-out path.
// Optional even parity per word when STREAM_MEM_PARITY_EN is defined.
module stream_mem
   import stream_mem_pkg::*;
#(
   parameter int word_size    = 8,
   parameter int address_bits = 8,
   parameter int mem_size     = 2**address_bits
) (
   input logic         clk,
   input logic         rst_n,
   stream_mem_if.slave bus
);

`ifdef STREAM_MEM_PARITY_EN
   localparam int arr_w = word_size + 1;
`else
   localparam int arr_w = word_size;
`endif

   localparam logic [address_bits:0] mem_lim = (address_bits+1)'(mem_size);

   logic [arr_w-1:0]        flash [mem_size];
   logic [arr_w-1:0]        wr_word, host_word, strm_word;
   logic [address_bits-1:0] rd_addr;
   logic                    burst_idle, s_load;
   logic                    add_ok, strm_ok, host_accept, we;
   logic                    host_bad, strm_bad;

   logic [word_size-1:0]    data_r_q, data_r_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    host_err_q, host_err_d;
   logic                    par_err_q, par_err_d;

   assign add_ok    = {1'b0, bus.add} < mem_lim;
   assign strm_ok   = {1'b0, rd_addr} < mem_lim;
   assign host_word = add_ok  ? flash[bus.add] : '0;
   assign strm_word = strm_ok ? flash[rd_addr] : '0;

   // A burst_start accepted this cycle takes priority over any host access.
   assign host_accept = bus.enable && burst_idle && !bus.burst_start;
   assign we          = host_accept && (bus.RW == RW_WRITE) && add_ok;

`ifdef STREAM_MEM_PARITY_EN
   assign wr_word  = {even_parity(64'(bus.data_w)), bus.data_w};
   assign host_bad = add_ok  && (^host_word);
   assign strm_bad = strm_ok && (^strm_word);
`else
   assign wr_word  = bus.data_w;
   assign host_bad = 1'b0;
   assign strm_bad = 1'b0;
`endif

   always_comb begin
      rd_valid_d = host_accept && (bus.RW == RW_READ);
      data_r_d   = rd_valid_d ? host_word[word_size-1:0] : data_r_q;
      host_err_d = bus.enable && (!host_accept || !add_ok);
      par_err_d  = (rd_valid_d && host_bad) || (s_load && strm_bad);
   end

   always_ff @(posedge clk) begin
      if (we) flash[bus.add] <= wr_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_r_q   <= '0;
         rd_valid_q <= 1'b0;
         host_err_q <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         data_r_q   <= data_r_d;
         rd_valid_q <= rd_valid_d;
         host_err_q <= host_err_d;
         par_err_q  <= par_err_d;
      end
   end

   stream_mem_burst_ctrl #(
      .word_size    (word_size),
      .address_bits (address_bits),
      .mem_size     (mem_size)
   ) u_burst_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .burst_start (bus.burst_start),
      .burst_base  (bus.burst_base),
      .burst_len   (bus.burst_len),
      .s_ready     (bus.s_ready),
      .rd_word     (strm_word[word_size-1:0]),
      .rd_addr     (rd_addr),
      .s_load      (s_load),
      .idle        (burst_idle),
      .s_data      (bus.s_data),
      .s_valid     (bus.s_valid),
      .s_last      (bus.s_last),
      .busy        (bus.busy),
      .done        (bus.done)
   );

   assign bus.data_r   = data_r_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.host_err = host_err_q;
   assign bus.par_err  = par_err_q;

endmodule
